// File: rtl/dl11_multi_bridge_if.sv
// dl11_multi_bridge_if -- bus bundle for the multi-channel DL11 bridge.
//   cpu_*    : DCJ11 I/O-page register access (sel strobe, addr, wr, byte,
//              wdata in; hit, rdata out, both combinational)
//   bus_init : RESET instruction / GP code 014 pulse
//   a2_*     : Apple II slot window (sel strobe, wr, addr, wdata in;
//              registered rdata out)
//   irq*     : level request, vector of top pending request, ack pulse
// master = CPU/Apple side driving the bridge, slave = the bridge itself.
interface dl11_multi_bridge_if;
  logic        cpu_sel;
  logic [21:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_byte;
  logic [15:0] cpu_wdata;
  logic        cpu_hit;
  logic [15:0] cpu_rdata;
  logic        bus_init;
  logic        a2_sel;
  logic        a2_wr;
  logic [3:0]  a2_addr;
  logic [7:0]  a2_wdata;
  logic [7:0]  a2_rdata;
  logic        irq;
  logic [8:0]  irq_vec;
  logic        irq_ack;

  modport master (
    output cpu_sel, cpu_addr, cpu_wr, cpu_byte, cpu_wdata, bus_init,
           a2_sel, a2_wr, a2_addr, a2_wdata, irq_ack,
    input  cpu_hit, cpu_rdata, a2_rdata, irq, irq_vec
  );

  modport slave (
    input  cpu_sel, cpu_addr, cpu_wr, cpu_byte, cpu_wdata, bus_init,
           a2_sel, a2_wr, a2_addr, a2_wdata, irq_ack,
    output cpu_hit, cpu_rdata, a2_rdata, irq, irq_vec
  );
endinterface

// File: rtl/dl11_multi_bridge.sv
// dl11_multi_bridge -- NCH DL11 console channels bridged between the DCJ11
// I/O page and an Apple II slot window, each with RX/TX byte FIFOs and
// RX/TX interrupts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dl11_multi_bridge_if.slave (CPU regs, Apple regs, irq)
// Optional feature macro: DL11_MAINT_EN (XCSR bit2 MAINT loopback of XBUF
// writes into the same channel's RX FIFO).

// Byte FIFO; full/empty decisions use the count from before this cycle.
module dl11_multi_bridge_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0; rp <= '0; count <= '0;
    end else if (clr) begin
      wp <= '0; rp <= '0; count <= '0;
    end else begin
      wp    <= wp + AW'(push_ok);
      rp    <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end

  always_ff @(posedge clk)
    if (push_ok && !clr) mem[wp] <= wdata;
endmodule

// One DL11 channel: register quad, Apple window, FIFOs, interrupt pending.
module dl11_multi_bridge_chan #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [21:0] BASE       = 22'o17777560,
  parameter logic [8:0]  RX_VEC     = 9'o060,
  parameter logic [8:0]  TX_VEC     = 9'o064,
  parameter logic [1:0]  IDX        = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_init,
  input  logic        cpu_sel,
  input  logic [21:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_byte,
  input  logic [7:0]  cpu_wdata,
  input  logic        a2_sel,
  input  logic        a2_wr,
  input  logic [3:0]  a2_addr,
  input  logic [7:0]  a2_wdata,
  input  logic        irq_ack,
  input  logic [8:0]  irq_vec,
  output logic        hit,
  output logic [15:0] rdata,
  output logic [7:0]  a2_rd,
  output logic        rx_pend,
  output logic        tx_pend
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    rsel;
  logic          acc, rd, wr, a2_hit;
  logic          rbuf_rd, xbuf_wr, a2_push, a2_pop, flush, fifo_clr;
  logic          rx_push, tx_push, ovr_set, maint_bit;
  logic [7:0]    rx_wd, rx_head, tx_head;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_ie, tx_ie, ovr, rx_prev, tx_prev;
  logic          rx_cond, tx_cond, rx_ie_d, tx_ie_d, rx_ack, tx_ack;
  logic [6:0]    tx_cnt_w;
  logic [4:0]    tx_cnt_sat;

  assign hit  = (cpu_addr[21:3] == BASE[21:3]);
  assign rsel = cpu_addr[2:1];
  // bus_init outranks any access on the same cycle
  assign acc  = cpu_sel & hit & ~bus_init;
  assign rd   = acc & ~cpu_wr;
  assign wr   = acc & cpu_wr & ~(cpu_byte & cpu_addr[0]);

  assign a2_hit  = a2_sel & (a2_addr[3:2] == IDX) & ~bus_init;
  assign a2_push = a2_hit & a2_wr & (a2_addr[1:0] == 2'd2);
  assign a2_pop  = a2_hit & ~a2_wr & (a2_addr[1:0] == 2'd1);
  assign flush   = a2_hit & a2_wr & (a2_addr[1:0] == 2'd3) & a2_wdata[0];
  assign fifo_clr = bus_init | flush;

  assign rbuf_rd = rd & (rsel == 2'd1);
  assign xbuf_wr = wr & (rsel == 2'd3);

`ifdef DL11_MAINT_EN
  logic maint, loop_push;
  assign maint_bit = maint;
  assign loop_push = xbuf_wr & maint;
  assign tx_push   = xbuf_wr & ~maint;
  // RX has one write port: an Apple push wins and a coincident loopback
  // byte is lost, which is reported as overrun.
  assign rx_push   = a2_push | loop_push;
  assign rx_wd     = a2_push ? a2_wdata : cpu_wdata;
  assign ovr_set   = (a2_push & rx_full) | (loop_push & (rx_full | a2_push));
`else
  assign maint_bit = 1'b0;
  assign tx_push   = xbuf_wr;
  assign rx_push   = a2_push;
  assign rx_wd     = a2_wdata;
  assign ovr_set   = a2_push & rx_full;
`endif

  dl11_multi_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .clr(fifo_clr), .push(rx_push), .pop(rbuf_rd),
    .wdata(rx_wd), .rdata(rx_head), .count(rx_cnt), .empty(rx_empty), .full(rx_full)
  );

  dl11_multi_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .clr(fifo_clr), .push(tx_push), .pop(a2_pop),
    .wdata(cpu_wdata), .rdata(tx_head), .count(tx_cnt), .empty(tx_empty), .full(tx_full)
  );

  always_comb begin
    rdata = '0;
    case (rsel)
      2'd0: rdata = {8'b0, ~rx_empty, rx_ie, 6'b0};
      2'd1: rdata = {1'b0, ovr, 6'b0, rx_empty ? 8'h00 : rx_head};
      2'd2: rdata = {8'b0, ~tx_full, tx_ie, 3'b0, maint_bit, 2'b0};
      default: rdata = '0;
    endcase
  end

  assign tx_cnt_w   = 7'(tx_cnt);
  assign tx_cnt_sat = (tx_cnt_w > 7'd31) ? 5'd31 : tx_cnt_w[4:0];

  always_comb begin
    a2_rd = '0;
    case (a2_addr[1:0])
      2'd0: a2_rd = {~tx_empty, rx_full, ovr, tx_cnt_sat};
      2'd1: a2_rd = tx_empty ? 8'h00 : tx_head;
      default: a2_rd = '0;
    endcase
  end

  // Interrupt conditions; pending bits follow the IE value being written
  // this cycle so clearing IE drops the request on the next edge.
  assign rx_cond = ~rx_empty & rx_ie;
  assign tx_cond = ~tx_full & tx_ie;
  assign rx_ie_d = (wr && rsel == 2'd0) ? cpu_wdata[6] : rx_ie;
  assign tx_ie_d = (wr && rsel == 2'd2) ? cpu_wdata[6] : tx_ie;
  assign rx_ack  = irq_ack & rx_pend & (irq_vec == RX_VEC);
  assign tx_ack  = irq_ack & tx_pend & (irq_vec == TX_VEC);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_ie <= 1'b0; tx_ie <= 1'b0; ovr <= 1'b0;
      rx_prev <= 1'b0; tx_prev <= 1'b0; rx_pend <= 1'b0; tx_pend <= 1'b0;
`ifdef DL11_MAINT_EN
      maint <= 1'b0;
`endif
    end else if (bus_init) begin
      rx_ie <= 1'b0; tx_ie <= 1'b0; ovr <= 1'b0;
      rx_prev <= 1'b0; tx_prev <= 1'b0; rx_pend <= 1'b0; tx_pend <= 1'b0;
`ifdef DL11_MAINT_EN
      maint <= 1'b0;
`endif
    end else begin
      rx_ie <= rx_ie_d;
      tx_ie <= tx_ie_d;
`ifdef DL11_MAINT_EN
      if (wr && rsel == 2'd2) maint <= cpu_wdata[2];
`endif
      // a fresh loss outranks the clear from a coincident RBUF read
      if (ovr_set)      ovr <= 1'b1;
      else if (rbuf_rd) ovr <= 1'b0;
      rx_prev <= rx_cond;
      tx_prev <= tx_cond;
      rx_pend <= rx_ie_d & ((rx_cond & ~rx_prev) | (rx_pend & ~rx_ack));
      tx_pend <= tx_ie_d & ((tx_cond & ~tx_prev) | (tx_pend & ~tx_ack));
    end
endmodule

module dl11_multi_bridge #(
  parameter int          NCH        = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [21:0] CONS_BASE  = 22'o17777560,
  parameter logic [21:0] ALT_BASE   = 22'o17776500
) (
  input logic                clk,
  input logic                rst_n,
  dl11_multi_bridge_if.slave bus
);
  function automatic logic [21:0] base_of(input int i);
    return (i == 0) ? CONS_BASE : ALT_BASE + 22'(8 * (i - 1));
  endfunction

  function automatic logic [8:0] vec_of(input int i);
    return (i == 0) ? 9'o060 : 9'(9'o300 + 8 * (i - 1));
  endfunction

  logic [NCH-1:0]       hit, rx_pend, tx_pend;
  logic [NCH-1:0][15:0] ch_rdata;
  logic [NCH-1:0][7:0]  ch_a2rd;
  logic [15:0]          rdata;
  logic [7:0]           a2_nxt, a2_rdata_q;
  logic [8:0]           vec_nxt, irq_vec_q;
  logic                 unused_wdata;

  assign unused_wdata = ^bus.cpu_wdata[15:8];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dl11_multi_bridge_chan #(
      .FIFO_DEPTH(FIFO_DEPTH), .BASE(base_of(i)),
      .RX_VEC(vec_of(i)), .TX_VEC(vec_of(i) + 9'o4), .IDX(2'(i))
    ) u_chan (
      .clk(clk), .rst_n(rst_n), .bus_init(bus.bus_init),
      .cpu_sel(bus.cpu_sel), .cpu_addr(bus.cpu_addr), .cpu_wr(bus.cpu_wr),
      .cpu_byte(bus.cpu_byte), .cpu_wdata(bus.cpu_wdata[7:0]),
      .a2_sel(bus.a2_sel), .a2_wr(bus.a2_wr), .a2_addr(bus.a2_addr),
      .a2_wdata(bus.a2_wdata), .irq_ack(bus.irq_ack), .irq_vec(irq_vec_q),
      .hit(hit[i]), .rdata(ch_rdata[i]), .a2_rd(ch_a2rd[i]),
      .rx_pend(rx_pend[i]), .tx_pend(tx_pend[i])
    );
  end

  // channel windows are disjoint, so at most one hit is set
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (hit[i]) rdata = ch_rdata[i];
  end

  // channel indices at or above NCH match nothing and read 0
  always_comb begin
    a2_nxt = '0;
    for (int i = 0; i < NCH; i++)
      if (bus.a2_addr[3:2] == 2'(i)) a2_nxt = ch_a2rd[i];
  end

  // scan high to low so the lowest channel, RX before TX, is left standing
  always_comb begin
    vec_nxt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (tx_pend[i]) vec_nxt = vec_of(i) + 9'o4;
      if (rx_pend[i]) vec_nxt = vec_of(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_vec_q  <= '0;
      a2_rdata_q <= '0;
    end else if (bus.bus_init) begin
      irq_vec_q  <= '0;
      a2_rdata_q <= '0;
    end else begin
      irq_vec_q <= vec_nxt;
      if (bus.a2_sel && !bus.a2_wr) a2_rdata_q <= a2_nxt;
    end

  assign bus.cpu_hit   = |hit;
  assign bus.cpu_rdata = rdata;
  assign bus.a2_rdata  = a2_rdata_q;
  assign bus.irq       = (|rx_pend) | (|tx_pend);
  assign bus.irq_vec   = irq_vec_q;
endmodule

// File: tb/tb_dl11_multi_bridge.sv
module tb_dl11_multi_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dl11_multi_bridge_if ifc ();

  dl11_multi_bridge #(.NCH(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] RCSR0 = 22'o17777560, RBUF0 = 22'o17777562;
  localparam logic [21:0] XCSR0 = 22'o17777564, XBUF0 = 22'o17777566;
  localparam logic [21:0] RCSR1 = 22'o17776500, RBUF1 = 22'o17776502;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [15:0] d, input logic b);
    @(negedge clk);
    ifc.cpu_sel = 1'b1; ifc.cpu_wr = 1'b1; ifc.cpu_addr = a;
    ifc.cpu_byte = b; ifc.cpu_wdata = d;
    @(negedge clk);
    ifc.cpu_sel = 1'b0; ifc.cpu_wr = 1'b0; ifc.cpu_byte = 1'b0;
  endtask

  task automatic cpu_read(input logic [21:0] a, output logic [15:0] d);
    @(negedge clk);
    ifc.cpu_sel = 1'b1; ifc.cpu_wr = 1'b0; ifc.cpu_addr = a;
    #1 d = ifc.cpu_rdata;
    @(negedge clk);
    ifc.cpu_sel = 1'b0;
  endtask

  task automatic a2_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ifc.a2_sel = 1'b1; ifc.a2_wr = 1'b1; ifc.a2_addr = a; ifc.a2_wdata = d;
    @(negedge clk);
    ifc.a2_sel = 1'b0; ifc.a2_wr = 1'b0;
  endtask

  task automatic a2_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    ifc.a2_sel = 1'b1; ifc.a2_wr = 1'b0; ifc.a2_addr = a;
    @(negedge clk);
    ifc.a2_sel = 1'b0;
    d = ifc.a2_rdata;
  endtask

  task automatic pulse_ack();
    @(negedge clk); ifc.irq_ack = 1'b1;
    @(negedge clk); ifc.irq_ack = 1'b0;
  endtask

  task automatic pulse_init();
    @(negedge clk); ifc.bus_init = 1'b1;
    @(negedge clk); ifc.bus_init = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  b;

    rst_n = 1'b0;
    ifc.cpu_sel = 0; ifc.cpu_addr = '0; ifc.cpu_wr = 0; ifc.cpu_byte = 0;
    ifc.cpu_wdata = '0; ifc.bus_init = 0; ifc.a2_sel = 0; ifc.a2_wr = 0;
    ifc.a2_addr = '0; ifc.a2_wdata = '0; ifc.irq_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_irq", 16'(ifc.irq), 16'h0);
    chk("rst_vec", 16'(ifc.irq_vec), 16'h0);
    chk("rst_a2rd", 16'(ifc.a2_rdata), 16'h0);
    rst_n = 1'b1;

    // address decode
    ifc.cpu_addr = RBUF0;          #1 chk("hit_ch0", 16'(ifc.cpu_hit), 16'h1);
    ifc.cpu_addr = 22'o17777570;   #1 chk("hit_above_ch0", 16'(ifc.cpu_hit), 16'h0);
    ifc.cpu_addr = 22'o17776506;   #1 chk("hit_ch1_xbuf", 16'(ifc.cpu_hit), 16'h1);
    ifc.cpu_addr = 22'o17776510;   #1 chk("hit_no_ch2", 16'(ifc.cpu_hit), 16'h0);

    cpu_read(RCSR0, w); chk("rst_rcsr0", w, 16'o000000);
    cpu_read(XCSR0, w); chk("rst_xcsr0", w, 16'o000200);

    // Apple -> CPU receive path
    a2_write(4'h2, 8'h41);
    a2_write(4'h2, 8'h42);
    cpu_read(RCSR0, w); chk("rx_done", w, 16'o000200);
    cpu_read(RBUF0, w); chk("rbuf_1st", w, 16'o000101);
    cpu_read(RBUF0, w); chk("rbuf_2nd", w, 16'o000102);
    cpu_read(RCSR0, w); chk("rx_drained", w, 16'o000000);
    cpu_read(RBUF0, w); chk("rbuf_empty", w, 16'o000000);

    // CPU -> Apple transmit path, overfill by one
    for (int i = 1; i <= 17; i++) cpu_write(XBUF0, 16'(i), 1'b0);
    cpu_read(XCSR0, w); chk("tx_full_xcsr", w, 16'o000000);
    a2_read(4'h0, b);   chk("tx_full_stat", 16'(b), 16'h90);
    for (int i = 1; i <= 16; i++) begin
      a2_read(4'h1, b); chk("tx_pop", 16'(b), 16'(i));
    end
    a2_read(4'h1, b);   chk("tx_pop_empty", 16'(b), 16'h0);
    cpu_read(XCSR0, w); chk("tx_ready_again", w, 16'o000200);

    // byte lanes: odd ignored, even pushes
    cpu_write(XBUF0 + 22'd1, 16'h0077, 1'b1);
    a2_read(4'h0, b);   chk("odd_byte_ignored", 16'(b), 16'h00);
    cpu_write(XBUF0, 16'h0033, 1'b1);
    a2_read(4'h0, b);   chk("even_byte_push", 16'(b), 16'h81);
    a2_read(4'hC, b);   chk("a2_ch3_reads0", 16'(b), 16'h00);
    a2_write(4'h3, 8'h01);
    a2_read(4'h0, b);   chk("flush_stat", 16'(b), 16'h00);

    // ch1 RX overrun
    for (int i = 1; i <= 17; i++) a2_write(4'h6, 8'(i));
    a2_read(4'h4, b);   chk("ch1_ovr_stat", 16'(b), 16'h60);
    cpu_read(RBUF1, w); chk("ch1_rbuf_ovr", w, 16'o040001);
    cpu_read(RBUF1, w); chk("ch1_rbuf_noovr", w, 16'o000002);
    a2_write(4'h7, 8'h01);
    cpu_read(RCSR1, w); chk("ch1_flushed", w, 16'o000000);
    a2_write(4'hE, 8'h99);
    cpu_read(RCSR0, w); chk("ch3_write_ignored", w, 16'o000000);

    // interrupts and priority
    cpu_write(RCSR0, 16'o000100, 1'b0);
    cpu_write(RCSR1, 16'o000100, 1'b0);
    cpu_read(RCSR0, w); chk("rcsr_ie", w, 16'o000100);
    chk("irq_idle", 16'(ifc.irq), 16'h0);
    a2_write(4'h2, 8'h11);
    a2_write(4'h6, 8'h22);
    repeat (2) @(negedge clk);
    chk("irq_set", 16'(ifc.irq), 16'h1);
    chk("vec_ch0rx", 16'(ifc.irq_vec), 16'o060);
    pulse_ack();
    repeat (2) @(negedge clk);
    chk("vec_ch1rx", 16'(ifc.irq_vec), 16'o300);
    chk("irq_still", 16'(ifc.irq), 16'h1);
    pulse_ack();
    repeat (2) @(negedge clk);
    chk("irq_clear", 16'(ifc.irq), 16'h0);
    chk("vec_clear", 16'(ifc.irq_vec), 16'h0);
    pulse_ack();
    repeat (2) @(negedge clk);
    chk("ack_ignored", 16'(ifc.irq_vec), 16'h0);
    // re-enabling IE with DONE already set raises a new request
    cpu_write(RCSR0, 16'o000000, 1'b0);
    cpu_write(RCSR0, 16'o000100, 1'b0);
    repeat (2) @(negedge clk);
    chk("ie_edge_irq", 16'(ifc.irq), 16'h1);
    chk("ie_edge_vec", 16'(ifc.irq_vec), 16'o060);
    cpu_write(RCSR0, 16'o000000, 1'b0);
    @(negedge clk);
    chk("ie_clr_irq", 16'(ifc.irq), 16'h0);
    cpu_read(RBUF0, w); chk("ch0_byte", w, 16'o000021);
    cpu_read(RBUF1, w); chk("ch1_byte", w, 16'o000042);
    cpu_write(RCSR1, 16'o000000, 1'b0);

    // TX interrupt, then bus_init
    for (int i = 1; i <= 5; i++) cpu_write(XBUF0, 16'(i), 1'b0);
    cpu_write(XCSR0, 16'o000100, 1'b0);
    repeat (2) @(negedge clk);
    chk("tx_irq_vec", 16'(ifc.irq_vec), 16'o064);
    a2_read(4'h0, b);   chk("tx5_stat", 16'(b), 16'h85);
    pulse_init();
    chk("init_irq", 16'(ifc.irq), 16'h0);
    chk("init_vec", 16'(ifc.irq_vec), 16'h0);
    chk("init_a2rd", 16'(ifc.a2_rdata), 16'h0);
    cpu_read(XCSR0, w); chk("init_xcsr", w, 16'o000200);
    a2_read(4'h0, b);   chk("init_txcnt", 16'(b), 16'h00);

    // init coincident with accesses discards them
    @(negedge clk);
    ifc.bus_init = 1'b1;
    ifc.a2_sel = 1'b1; ifc.a2_wr = 1'b1; ifc.a2_addr = 4'h2; ifc.a2_wdata = 8'h77;
    ifc.cpu_sel = 1'b1; ifc.cpu_wr = 1'b1; ifc.cpu_addr = XBUF0; ifc.cpu_wdata = 16'h0066;
    @(negedge clk);
    ifc.bus_init = 1'b0; ifc.a2_sel = 1'b0; ifc.a2_wr = 1'b0;
    ifc.cpu_sel = 1'b0; ifc.cpu_wr = 1'b0;
    cpu_read(RCSR0, w); chk("init_wins_rx", w, 16'o000000);
    a2_read(4'h0, b);   chk("init_wins_tx", 16'(b), 16'h00);

    // asynchronous reset in the middle of activity
    cpu_write(RCSR0, 16'o000100, 1'b0);
    a2_write(4'h2, 8'h12);
    repeat (2) @(negedge clk);
    chk("pre_rst_irq", 16'(ifc.irq), 16'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_irq", 16'(ifc.irq), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    cpu_read(RCSR0, w); chk("rst_rcsr_clear", w, 16'o000000);

`ifdef DL11_MAINT_EN
    cpu_write(XCSR0, 16'o000004, 1'b0);
    cpu_read(XCSR0, w); chk("maint_xcsr", w, 16'o000204);
    cpu_write(XBUF0, 16'h0055, 1'b0);
    cpu_read(RBUF0, w); chk("maint_loop", w, 16'o000125);
    a2_read(4'h0, b);   chk("maint_tx_empty", 16'(b), 16'h00);
`else
    cpu_write(XCSR0, 16'o000004, 1'b0);
    cpu_read(XCSR0, w); chk("no_maint_xcsr", w, 16'o000200);
    cpu_write(XBUF0, 16'h0055, 1'b0);
    a2_read(4'h0, b);   chk("no_maint_tx", 16'(b), 16'h81);
    cpu_read(RBUF0, w); chk("no_maint_rx", w, 16'o000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dl11_multi_bridge.md
Name: dl11_multi_bridge

Overview:
- Parametrised multi-channel DL11 console bridge between the DCJ11 bus front-end and the Apple II slot interface.
- Each channel has a DL11 register quad (RCSR/RBUF/XCSR/XBUF) on the PDP-11 side and a small Apple II register window on the other.
- Each channel buffers bytes in independent RX and TX FIFOs, replacing the single-byte strobe/ready handshake.
- Adds per-channel interrupt request with vector output and acknowledge, and bus-INIT handling.

Parameters:
- NCH, 2, number of DL11 channels (1..4).
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..64.
- CONS_BASE, 22'o17777560, channel 0 register base; channel 0 vectors 060 (RX) and 064 (TX).
- ALT_BASE, 22'o17776500, channel i≥1 base = ALT_BASE + 8*(i-1); vectors 0300+8*(i-1) (RX) and +4 (TX).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_sel  in  1  one-cycle strobe, CPU register access in I/O page.
- cpu_addr  in  22  physical address of access.
- cpu_wr  in  1  1 = write, 0 = read (qualified by cpu_sel).
- cpu_byte  in  1  byte write; cpu_addr[0] selects byte lane.
- cpu_wdata  in  16  write data.
- cpu_hit  out  1  combinational: cpu_addr decodes to any channel register.
- cpu_rdata  out  16  combinational read data for cpu_addr.
- bus_init  in  1  one-cycle pulse, RESET instruction / GP code 014.
- a2_sel  in  1  one-cycle strobe, Apple II access, already synchronised to clk.
- a2_wr  in  1  1 = Apple write.
- a2_addr  in  4  [3:2] channel, [1:0] register.
- a2_wdata  in  8  Apple write data.
- a2_rdata  out  8  registered Apple read data.
- irq  out  1  interrupt request, level.
- irq_vec  out  9  vector of highest-priority pending request.
- irq_ack  in  1  one-cycle pulse, vector irq_vec taken.

Behaviour:
- Reset and bus_init: all FIFOs empty, IE bits 0, overrun 0, pending 0, irq 0, irq_vec 0, a2_rdata 0.
- CPU side, per channel:
  - RCSR: bit7 DONE = RX FIFO non-empty; bit6 IE is R/W; all other bits read 0.
  - RBUF read: [7:0] = RX head, [14] = overrun, rest 0. Pops the head and clears overrun on the cpu_sel cycle. Empty read returns [7:0]=0 with no pop.
  - XCSR: bit7 READY = TX FIFO not full; bit6 IE is R/W.
  - XBUF: write (word, or byte with addr[0]=0) pushes wdata[7:0]; write while full is dropped. Reads return 0.
  - Byte writes to odd addresses are ignored.
  - Address match uses cpu_addr[21:3] vs base[21:3], register = cpu_addr[2:1].
- Apple side, register a2_addr[1:0]:
  - 0 read status: bit7 TX non-empty, bit6 RX full, bit5 overrun, [4:0] = TX count saturated at 31.
  - 1 read: pops TX head into a2_rdata; empty returns 0.
  - 2 write: pushes a2_wdata to RX. Push into a full RX FIFO drops the byte and sets overrun.
  - 3 write bit0=1: flush both FIFOs of that channel.
  - a2_rdata is valid the cycle after a2_sel.
  - Channel index ≥ NCH: reads 0, writes ignored.
- FIFOs:
  - Pointer wrap modulo FIFO_DEPTH; count width log2(DEPTH)+1.
  - Push and pop on the same cycle both occur, count unchanged. Full/empty decisions use the pre-cycle count, so a push into a full FIFO is dropped even with a simultaneous pop.
  - Status bits update on the cycle after the push or pop.
- Interrupts:
  - Per channel, rx_pend sets on the rising edge of (DONE & IE); tx_pend sets on the rising edge of (READY & IE). Setting IE while DONE or READY is already 1 counts as a rising edge.
  - Pending clears when IE clears, or on irq_ack while its vector is presented.
  - Priority: lowest channel first, RX before TX.
  - irq = OR of pending bits; irq_vec registered one cycle after a pending change.
  - irq_ack with no pending request is ignored.
- bus_init coincident with any access: init wins, access discarded.
- Reset asserted mid-access: everything clears immediately.

Optional Feature:
- Macro DL11_MAINT_EN.
  - Defined: XCSR bit2 is MAINT, R/W, cleared by reset/init. While MAINT=1, XBUF writes push into the same channel's RX FIFO (overrun rules apply) instead of TX.
  - Undefined: XCSR bit2 reads 0 and writes are ignored; no loopback path is synthesised.

Test Plan:
- Apple writes 0x41, 0x42 to ch0 reg 2 -> RCSR reads 0o000200; RBUF reads 0o000101 then 0o000102; RCSR then reads 0.
- CPU writes 17 bytes to XBUF 17777566 (DEPTH 16) -> 17th dropped, XCSR READY=0; Apple status reads 0x90; sixteen reg-1 reads return bytes 1..16 in order.
- Apple pushes 17 bytes into ch1 RX -> RBUF at 17776502 reads bit14=1 on first read; second read bit14=0.
- Set RCSR IE on ch0 and ch1, push one RX byte to each -> irq=1, irq_vec=060; irq_ack -> irq_vec=0300; irq_ack -> irq=0.
- Fill ch0 TX with 5 bytes, set IE, pulse bus_init -> TX count 0, IE=0, irq=0, XCSR reads 0o000200.
- DL11_MAINT_EN: set XCSR=0o000004, write XBUF 0x55 -> RBUF reads 0o000125; Apple TX status bit7=0.
